// File: rtl/jkff_excite_driver.sv
// ---------------------------------------------------------------------------
// jkff_excite_driver
//
// Driving end for an external JK flip-flop. Target Q values arrive over a
// valid/ready handshake and are buffered in a small FIFO. One target per
// cycle is turned into registered J/K excitation using the minimal-toggle
// encoding, which never produces J=K=1. The block also tracks the Q it
// expects the flip-flop to have, and can check the fed-back Q against it.
//
// Optional feature macro: JKDRV_CHECK_EN
//   defined   - the fed-back Q is checked. A mismatch moves the FSM to ERROR,
//               which stops popping and raises err until err_clr.
//   undefined - q_fb is not compared, err is 0, ERROR is never entered.
//
// Parameters
//   DEPTH  target FIFO depth, power of two, 2..16
//   CW     width of level, log2(DEPTH)+1
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, shared with the flip-flop
//   tgt_valid  a target bit is offered
//   tgt_bit    desired flip-flop Q after it is driven
//   tgt_ready  FIFO can accept a bit (not full)
//   j, k       registered excitation to the flip-flop
//   q_fb       Q fed back from the flip-flop
//   exp_q      expected flip-flop Q after the next edge
//   busy       FIFO non-empty or FSM in RUN
//   level      FIFO occupancy, 0..DEPTH
//   err        sticky mismatch flag
//   err_clr    clears err and resynchronises the expected Q to q_fb
// ---------------------------------------------------------------------------
module jkff_excite_driver #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tgt_valid,
    input  logic          tgt_bit,
    output logic          tgt_ready,
    output logic          j,
    output logic          k,
    input  logic          q_fb,
    output logic          exp_q,
    output logic          busy,
    output logic [CW-1:0] level,
    output logic          err,
    input  logic          err_clr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             head;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             mismatch;
    logic             resync;

    assign empty     = (level == '0);
    assign full      = (level == CW'(DEPTH));
    assign tgt_ready = ~full;
    assign push      = tgt_valid & ~full;
    // Pop eligibility is decided on the occupancy before the edge, so a bit
    // pushed into an empty FIFO is popped one edge later.
    assign pop       = ~empty & (state != S_ERROR);
    assign head      = mem[rd_ptr];
    assign busy      = ~empty | (state == S_RUN);

`ifdef JKDRV_CHECK_EN
    // exp_d is exp_q delayed one edge: the flip-flop samples j/k one edge
    // after they are registered, so its Q lines up with exp_d.
    logic exp_d;

    assign mismatch = (state != S_ERROR) & (q_fb != exp_d);
    assign resync   = (state == S_ERROR) & err_clr;
    assign err      = (state == S_ERROR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_d <= 1'b0;
        end else if (resync) begin
            exp_d <= q_fb;
        end else begin
            exp_d <= exp_q;
        end
    end
`else
    logic unused_err_clr;

    assign mismatch       = 1'b0;
    assign resync         = 1'b0;
    assign err            = 1'b0;
    assign unused_err_clr = err_clr;
`endif

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves it unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_RUN: begin
                if (mismatch) begin
                    state_nxt = S_ERROR;
                end else if (pop) begin
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERROR: begin
                if (resync) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: FIFO storage is not reset; the pointers and level define which
    // entries are valid, so the contents after reset never matter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tgt_bit;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            j      <= 1'b0;
            k      <= 1'b0;
            exp_q  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push, pop})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase

            // Minimal-toggle encoding: drive J only to set a 0, K only to
            // clear a 1, otherwise hold. J and K are never both 1.
            if (pop) begin
                j     <= head & ~exp_q;
                k     <= ~head & exp_q;
                exp_q <= head;
            end else begin
                j <= 1'b0;
                k <= 1'b0;
                if (resync) begin
                    exp_q <= q_fb;
                end
            end
        end
    end

endmodule

// File: tb/tb_jkff_excite_driver.sv
// ---------------------------------------------------------------------------
// tb_jkff_excite_driver
//
// Drives jkff_excite_driver into a behavioural JK flip-flop whose Q is fed
// back as q_fb. A queue-based reference model tracks what every output must
// be, and a negedge process compares the DUT against it each cycle. Directed
// sections add hand-computed literal expectations. A stuck-at-0 control on
// the flip-flop provokes checker errors when JKDRV_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_jkff_excite_driver;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          tgt_valid = 1'b0;
    logic          tgt_bit   = 1'b0;
    logic          err_clr   = 1'b0;
    logic          tgt_ready;
    logic          j;
    logic          k;
    logic          q_fb;
    logic          exp_q;
    logic          busy;
    logic [CW-1:0] level;
    logic          err;

    // External JK flip-flop; stuck holds it at 0 to emulate a broken part.
    logic ff_q  = 1'b0;
    logic stuck = 1'b0;
    assign q_fb = ff_q;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit m_fifo[$];
    bit m_exp_q;
    bit m_exp_d;
    bit m_err;
    bit m_running;
    bit m_j;
    bit m_k;
    bit cmp_en = 1'b0;

    jkff_excite_driver #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_bit   (tgt_bit),
        .tgt_ready (tgt_ready),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .exp_q     (exp_q),
        .busy      (busy),
        .level     (level),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_exp_q   = 1'b0;
        m_exp_d   = 1'b0;
        m_err     = 1'b0;
        m_running = 1'b0;
        m_j       = 1'b0;
        m_k       = 1'b0;
    endtask

    // One clock edge of the reference behaviour, given the inputs that were
    // present before the edge.
    task automatic model_step(input bit v, input bit b, input bit c, input bit qf);
        int sz0;
        bit popped;
        bit t;
        bit old_exp;
        bit mism;
        sz0     = m_fifo.size();
        old_exp = m_exp_q;
        popped  = !m_err && (sz0 > 0);
        mism    = 1'b0;
`ifdef JKDRV_CHECK_EN
        mism = !m_err && (qf != m_exp_d);
`endif
        m_j = 1'b0;
        m_k = 1'b0;
        if (popped) begin
            t       = m_fifo.pop_front();
            m_j     = t & ~old_exp;
            m_k     = ~t & old_exp;
            m_exp_q = t;
        end
        if (v && sz0 < DEPTH) begin
            m_fifo.push_back(b);
        end
        if (m_err) begin
            m_running = 1'b0;
            if (c) begin
                m_err   = 1'b0;
                m_exp_q = qf;
                m_exp_d = qf;
            end else begin
                m_exp_d = old_exp;
            end
        end else begin
            m_exp_d   = old_exp;
            m_running = popped && !mism;
            if (mism) begin
                m_err = 1'b1;
            end
        end
    endtask

    // Advance one clock: capture pre-edge inputs and drives, then update the
    // flip-flop and the model just after the edge.
    task automatic step();
        bit v;
        bit b;
        bit c;
        bit qf;
        bit jj;
        bit kk;
        v  = tgt_valid;
        b  = tgt_bit;
        c  = err_clr;
        qf = q_fb;
        jj = j;
        kk = k;
        @(posedge clk);
        #1;
        if (stuck) begin
            ff_q = 1'b0;
        end else begin
            case ({jj, kk})
                2'b10:   ff_q = 1'b1;
                2'b01:   ff_q = 1'b0;
                2'b11:   ff_q = ~ff_q;
                default: ff_q = ff_q;
            endcase
        end
        model_step(v, b, c, qf);
    endtask

    task automatic apply_reset(input string tag);
        rst       = 1'b1;
        tgt_valid = 1'b0;
        err_clr   = 1'b0;
        stuck     = 1'b0;
        ff_q      = 1'b0;
        model_reset();
        #1;
        check({tag, "_j"},         8'(j),         8'h00);
        check({tag, "_k"},         8'(k),         8'h00);
        check({tag, "_exp_q"},     8'(exp_q),     8'h00);
        check({tag, "_level"},     8'(level),     8'h00);
        check({tag, "_busy"},      8'(busy),      8'h00);
        check({tag, "_tgt_ready"}, 8'(tgt_ready), 8'h01);
        check({tag, "_err"},       8'(err),       8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_bit(input bit b);
        tgt_valid = 1'b1;
        tgt_bit   = b;
        step();
        tgt_valid = 1'b0;
    endtask

`ifdef JKDRV_CHECK_EN
    // From a clean reset: flip-flop stuck at 0 while target 1 is driven.
    task automatic provoke_error(input bit pin_timing);
        stuck = 1'b1;
        push_bit(1'b1);
        step();
        step();
        if (pin_timing) check("err_before_e3", 8'(err), 8'h00);
        step();
        if (pin_timing) begin
            check("err_at_e3",   8'(err), 8'h01);
            check("err_state_j", 8'(j),   8'h00);
            check("err_state_k", 8'(k),   8'h00);
        end
        stuck = 1'b0;
    endtask
`endif

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_j",         8'(j),         8'(m_j));
            check("cyc_k",         8'(k),         8'(m_k));
            check("cyc_jk_excl",   8'(j & k),     8'h00);
            check("cyc_exp_q",     8'(exp_q),     8'(m_exp_q));
            check("cyc_level",     8'(level),     8'(m_fifo.size()));
            check("cyc_tgt_ready", 8'(tgt_ready), 8'(m_fifo.size() < DEPTH));
            check("cyc_busy",      8'(busy),      8'((m_fifo.size() > 0) || m_running));
            check("cyc_err",       8'(err),       8'(m_err));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         seq    [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] exp_jk [5] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        logic [1:0] jk_log [10];
        logic       q_log  [10];
        bit         s3     [3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0] exp3   [3] = '{2'b10, 2'b01, 2'b10};

        model_reset();
        cmp_en = 1'b1;
        #2;
        apply_reset("rst0");

        // Back-to-back stream 1,1,0,0,1 into the flip-flop.
        for (int i = 0; i < 10; i++) begin
            tgt_valid = (i < 5);
            tgt_bit   = (i < 5) ? seq[i] : 1'b0;
            step();
            jk_log[i] = {j, k};
            q_log[i]  = ff_q;
            if (i == 2) begin
                check("stream_level", 8'(level), 8'h01);
                check("stream_busy",  8'(busy),  8'h01);
            end
        end
        tgt_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stream_jk%0d", i), 8'(jk_log[i + 1]), 8'(exp_jk[i]));
            check($sformatf("stream_q%0d", i),  8'(q_log[i + 2]),  8'(seq[i]));
        end
        check("stream_err", 8'(err), 8'h00);

`ifdef JKDRV_CHECK_EN
        // Checker error, full FIFO while held in ERROR, then recovery.
        apply_reset("rst1");
        provoke_error(1'b1);
        for (int i = 0; i < 4; i++) begin
            push_bit(s3[i % 3]);
        end
        check("full_level", 8'(level),     8'h04);
        check("full_ready", 8'(tgt_ready), 8'h00);
        tgt_valid = 1'b1;
        tgt_bit   = 1'b0;
        err_clr   = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_err",   8'(err),   8'h00);
        check("clr_exp_q", 8'(exp_q), 8'h00);
        check("clr_level", 8'(level), 8'h04);
        step();
        check("resume_level", 8'(level),     8'h03);
        check("resume_ready", 8'(tgt_ready), 8'h01);
        step();
        tgt_valid = 1'b0;
        check("fifth_level", 8'(level), 8'h03);
        repeat (6) step();
        check("drain_err",  8'(err),  8'h00);
        check("drain_busy", 8'(busy), 8'h00);

        // Backlog of three for the mid-stream reset.
        apply_reset("rst2");
        provoke_error(1'b0);
        for (int i = 0; i < 3; i++) begin
            push_bit(s3[i]);
        end
        check("pre_rst_level", 8'(level), 8'h03);
`else
        // Mid-stream reset right after a J pulse is registered.
        apply_reset("rst2");
        tgt_valid = 1'b1;
        tgt_bit   = 1'b1;
        step();
        tgt_bit = 1'b0;
        step();
        tgt_valid = 1'b0;
        check("pre_rst_j",     8'(j),     8'h01);
        check("pre_rst_level", 8'(level), 8'h01);
`endif
        apply_reset("midrst");

        // First post-reset stream 1,0,1; q_fb is ignored without the checker.
`ifndef JKDRV_CHECK_EN
        stuck = 1'b1;
`endif
        for (int i = 0; i < 5; i++) begin
            tgt_valid = (i < 3);
            tgt_bit   = (i < 3) ? s3[i] : 1'b0;
            step();
            if (i >= 1 && i <= 3) begin
                check($sformatf("post_rst_jk%0d", i - 1), 8'({j, k}), 8'(exp3[i - 1]));
            end
        end
        tgt_valid = 1'b0;
        check("post_rst_err", 8'(err), 8'h00);
        stuck = 1'b0;

        // Randomised traffic with varying offer rates.
        apply_reset("rst3");
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 100; i++) begin
                tgt_valid = ($urandom_range(0, 9) < (2 + blk + (blk % 2) * 3));
                tgt_bit   = 1'($urandom_range(0, 1));
                err_clr   = ($urandom_range(0, 7) == 0);
`ifdef JKDRV_CHECK_EN
                if ($urandom_range(0, 29) == 0) stuck = ~stuck;
`endif
                step();
            end
        end
        tgt_valid = 1'b0;
        err_clr   = 1'b0;
        stuck     = 1'b0;
        repeat (8) step();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
